// File: rtl/dmem_access_ctrl_if.sv
// Bus bundle between the CPU load/store port, dmem_access_ctrl and the word-wide DataMemory.
// slave = the controller's view; master = the CPU plus memory side.
interface dmem_access_ctrl_if;
    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only when idle, and resp_valid is a one-cycle pulse with no backpressure.
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_access_addr;
    logic [31:0] mem_in;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [2:0]  mem_data_size;
    logic [31:0] mem_out;

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata, mem_out,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_access_addr, mem_in, mem_write_en, mem_read_en, mem_data_size
    );

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata, mem_out,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_access_addr, mem_in, mem_write_en, mem_read_en, mem_data_size
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Turns byte/half/word CPU loads and stores into whole-word DataMemory cycles (RMW for sub-word stores).
// Define MISALIGNED_SPLIT_EN to split word-crossing accesses; otherwise they are rejected with resp_err.
module dmem_access_ctrl #(
    parameter int ADDR_BITS = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_access_ctrl_if.slave bus,
    output logic [2:0]       dbg_state
);
    localparam int WB = ADDR_BITS - 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        WR0  = 3'd3,
        WR1  = 3'd4,
        RESP = 3'd5
    } state_t;

    state_t        state;
    logic [1:0]    off_q;
    logic [1:0]    kind_q;    // 0 byte, 1 half, 2 word
    logic          sign_q;
    logic          write_q;
    logic          span_q;
    logic [WB-1:0] w0_q;
    logic [31:0]   wdata_q;
    logic [31:0]   buf0;
    logic [31:0]   buf1;
    logic          resp_valid_q;
    logic [31:0]   resp_rdata_q;
    logic          resp_err_q;

    // Incoming request decode (only meaningful in IDLE).
    logic [1:0] in_kind;
    logic       in_sign;
    logic [1:0] in_off;
    logic [2:0] in_n;
    logic       in_span;
    logic       in_reject;

    always_comb begin
        in_kind = 2'd2;
        in_sign = 1'b0;
        case (bus.req_size)
            3'b000:  begin in_kind = 2'd0; in_sign = 1'b1; end
            3'b001:  begin in_kind = 2'd1; in_sign = 1'b1; end
            3'b100:  in_kind = 2'd0;
            3'b101:  in_kind = 2'd1;
            default: in_kind = 2'd2;
        endcase
    end

    assign in_off  = bus.req_addr[1:0];
    assign in_n    = (in_kind == 2'd0) ? 3'd1 : (in_kind == 2'd1) ? 3'd2 : 3'd4;
    assign in_span = ({1'b0, in_off} + in_n) > 3'd4;
`ifdef MISALIGNED_SPLIT_EN
    assign in_reject = 1'b0;
`else
    assign in_reject = in_span;
`endif

    logic [WB-1:0] w1;
    assign w1 = w0_q + WB'(1);

    // Load path: the word being read this cycle comes straight from mem_out.
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [63:0] pair;
    logic [31:0] raw;
    logic [31:0] load_result;

    assign rd0  = (state == RD0) ? bus.mem_out : buf0;
    assign rd1  = (state == RD1) ? bus.mem_out : buf1;
    assign pair = {rd1, rd0} >> {off_q, 3'b000};
    assign raw  = pair[31:0];

    always_comb begin
        case (kind_q)
            2'd0:    load_result = sign_q ? {{24{raw[7]}}, raw[7:0]} : {24'd0, raw[7:0]};
            2'd1:    load_result = sign_q ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
            default: load_result = raw;
        endcase
    end

    // Store path: data and byte mask laid across the two-word window starting at word0.
    logic [3:0]  byte_mask;
    logic [7:0]  wide_mask;
    logic [63:0] wide_data;

    assign byte_mask = (kind_q == 2'd0) ? 4'b0001 : (kind_q == 2'd1) ? 4'b0011 : 4'b1111;
    assign wide_mask = {4'd0, byte_mask} << off_q;
    assign wide_data = {32'd0, wdata_q} << {off_q, 3'b000};

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = m[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return r;
    endfunction

    // Memory-side outputs are a pure decode of the registered state and latched request.
    logic          rd_en;
    logic          wr_en;
    logic [WB-1:0] cur_word;
    logic [31:0]   cur_in;

    always_comb begin
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        cur_word = w0_q;
        cur_in   = 32'd0;
        case (state)
            RD0: rd_en = 1'b1;
            RD1: begin rd_en = 1'b1; cur_word = w1; end
            WR0: begin
                wr_en  = 1'b1;
                cur_in = merge_bytes(buf0, wide_data[31:0], wide_mask[3:0]);
            end
            WR1: begin
                wr_en    = 1'b1;
                cur_word = w1;
                cur_in   = merge_bytes(buf1, wide_data[63:32], wide_mask[7:4]);
            end
            default: ;
        endcase
    end

    assign bus.mem_read_en     = rd_en;
    assign bus.mem_write_en    = wr_en & rst_n;
    assign bus.mem_access_addr = (rd_en | wr_en) ? {{(30 - WB){1'b0}}, cur_word, 2'b00} : 32'd0;
    assign bus.mem_in          = cur_in;
    assign bus.mem_data_size   = 3'b010;
    assign bus.req_ready       = (state == IDLE);
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_rdata      = resp_rdata_q;
    assign bus.resp_err        = resp_err_q;
    assign dbg_state           = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            off_q        <= 2'd0;
            kind_q       <= 2'd0;
            sign_q       <= 1'b0;
            write_q      <= 1'b0;
            span_q       <= 1'b0;
            w0_q         <= '0;
            wdata_q      <= 32'd0;
            buf0         <= 32'd0;
            buf1         <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        off_q   <= in_off;
                        kind_q  <= in_kind;
                        sign_q  <= in_sign;
                        write_q <= bus.req_write;
                        span_q  <= in_span;
                        w0_q    <= bus.req_addr[ADDR_BITS-1:2];
                        wdata_q <= bus.req_wdata;
                        if (in_reject) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (bus.req_write && in_off == 2'd0 && in_kind == 2'd2) begin
                            state <= WR0;
                        end else begin
                            state <= RD0;
                        end
                    end
                end
                RD0: begin
                    buf0 <= bus.mem_out;
                    if (span_q) begin
                        state <= RD1;
                    end else if (write_q) begin
                        state <= WR0;
                    end else begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= load_result;
                    end
                end
                RD1: begin
                    buf1 <= bus.mem_out;
                    if (write_q) begin
                        state <= WR0;
                    end else begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= load_result;
                    end
                end
                WR0: begin
                    if (span_q) begin
                        state <= WR1;
                    end else begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                    end
                end
                WR1: begin
                    state        <= RESP;
                    resp_valid_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{bus.req_addr[31:ADDR_BITS], pair[63:32]};
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a 32-word behavioural DataMemory.
// Expected values are hand-computed; split-access expectations follow MISALIGNED_SPLIT_EN.
module tb_dmem_access_ctrl;
    logic       clk;
    logic       rst_n;
    logic [2:0] dbg_state;

    dmem_access_ctrl_if bus ();

    dmem_access_ctrl #(.ADDR_BITS(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [32];
    logic        pre_en;
    logic [4:0]  pre_idx;
    logic [31:0] pre_val;

    assign bus.mem_out = mem[bus.mem_access_addr[6:2]];

    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_val;
        else if (bus.mem_write_en) mem[bus.mem_access_addr[6:2]] <= bus.mem_in;
    end

    // Scoreboard counters and check helper
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Per-transaction observations
    int          r_k;
    logic [31:0] r_rdata;
    logic        r_err;
    int          r_nrd;
    int          r_nwr;
    logic [31:0] r_waddr [2];
    logic [31:0] r_wdata [2];

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pre_en  = 1'b1;
        pre_idx = idx[4:0];
        pre_val = val;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic run_req(input logic w, input logic [2:0] sz, input logic [31:0] a,
                           input logic [31:0] d);
        logic got;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_size  = sz;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        got     = 1'b0;
        r_k     = 0;
        r_rdata = 32'd0;
        r_err   = 1'b0;
        r_nrd   = 0;
        r_nwr   = 0;
        r_waddr[0] = 32'd0; r_waddr[1] = 32'd0;
        r_wdata[0] = 32'd0; r_wdata[1] = 32'd0;
        for (int k = 1; k <= 20; k++) begin
            if (bus.mem_read_en) r_nrd++;
            if (bus.mem_write_en) begin
                if (r_nwr < 2) begin
                    r_waddr[r_nwr] = bus.mem_access_addr;
                    r_wdata[r_nwr] = bus.mem_in;
                end
                r_nwr++;
            end
            if (bus.resp_valid) begin
                got     = 1'b1;
                r_k     = k;
                r_rdata = bus.resp_rdata;
                r_err   = bus.resp_err;
                break;
            end
            @(negedge clk);
        end
        chk("resp_seen", {31'd0, got}, 32'd1);
    endtask

`ifdef MISALIGNED_SPLIT_EN
    localparam int RST_K = 3;
`else
    localparam int RST_K = 2;
`endif

    // Directed sequence
    initial begin
        rst_n         = 1'b0;
        pre_en        = 1'b0;
        pre_idx       = 5'd0;
        pre_val       = 32'd0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_size  = 3'b010;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        chk("rst_req_ready",  {31'd0, bus.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_err",   {31'd0, bus.resp_err}, 32'd0);
        chk("rst_mem_rd",     {31'd0, bus.mem_read_en}, 32'd0);
        chk("rst_mem_wr",     {31'd0, bus.mem_write_en}, 32'd0);
        chk("rst_mem_addr",   bus.mem_access_addr, 32'd0);
        chk("rst_mem_in",     bus.mem_in, 32'd0);
        chk("rst_mem_size",   {29'd0, bus.mem_data_size}, 32'd2);
        chk("rst_state",      {29'd0, dbg_state}, 32'd0);
        rst_n = 1'b1;

        // Signed and unsigned byte loads
        preload(0, 32'h1122_8344);
        run_req(1'b0, 3'b000, 32'd1, 32'd0);
        chk("lb_data", r_rdata, 32'hFFFF_FF83);
        chk("lb_k",    r_k, 32'd2);
        chk("lb_err",  {31'd0, r_err}, 32'd0);
        run_req(1'b0, 3'b100, 32'd1, 32'd0);
        chk("lbu_data", r_rdata, 32'h0000_0083);
        chk("lbu_k",    r_k, 32'd2);

        // Halfword store: one read, one merged write
        preload(0, 32'h1122_3344);
        run_req(1'b1, 3'b001, 32'd2, 32'h0000_BEEF);
        chk("sh_k",     r_k, 32'd3);
        chk("sh_nrd",   r_nrd, 32'd1);
        chk("sh_nwr",   r_nwr, 32'd1);
        chk("sh_wdata", r_wdata[0], 32'hBEEF_3344);
        chk("sh_waddr", r_waddr[0], 32'd0);
        chk("sh_rdata", r_rdata, 32'd0);
        chk("sh_mem0",  mem[0], 32'hBEEF_3344);

        // Non-spanning misaligned loads work in either build
        run_req(1'b0, 3'b000, 32'd3, 32'd0);
        chk("lb3_data", r_rdata, 32'hFFFF_FFBE);
        run_req(1'b0, 3'b001, 32'd2, 32'd0);
        chk("lh2_data", r_rdata, 32'hFFFF_BEEF);
        chk("lh2_err",  {31'd0, r_err}, 32'd0);
        run_req(1'b0, 3'b101, 32'd2, 32'd0);
        chk("lhu2_data", r_rdata, 32'h0000_BEEF);

        // Aligned word store: no read
        run_req(1'b1, 3'b010, 32'd4, 32'hCAFE_F00D);
        chk("sw_k",     r_k, 32'd2);
        chk("sw_nrd",   r_nrd, 32'd0);
        chk("sw_waddr", r_waddr[0], 32'd4);
        chk("sw_wdata", r_wdata[0], 32'hCAFE_F00D);
        chk("sw_mem1",  mem[1], 32'hCAFE_F00D);

        // Spanning word load
        preload(1, 32'hDDCC_BBAA);
        preload(2, 32'h4433_2211);
        run_req(1'b0, 3'b010, 32'd6, 32'd0);
`ifdef MISALIGNED_SPLIT_EN
        chk("lw6_data", r_rdata, 32'h2211_DDCC);
        chk("lw6_k",    r_k, 32'd3);
        chk("lw6_err",  {31'd0, r_err}, 32'd0);
        chk("lw6_nrd",  r_nrd, 32'd2);
`else
        chk("lw6_data", r_rdata, 32'd0);
        chk("lw6_k",    r_k, 32'd1);
        chk("lw6_err",  {31'd0, r_err}, 32'd1);
        chk("lw6_nrd",  r_nrd, 32'd0);
`endif

        // Spanning store across the wrap from word 31 to word 0, address aliased above ADDR_BITS
        preload(31, 32'h1111_1111);
        preload(0, 32'h2222_2222);
        run_req(1'b1, 3'b010, 32'h0000_017E, 32'h8765_4321);
`ifdef MISALIGNED_SPLIT_EN
        chk("span_k",     r_k, 32'd5);
        chk("span_nrd",   r_nrd, 32'd2);
        chk("span_nwr",   r_nwr, 32'd2);
        chk("span_waddr", r_waddr[1], 32'd0);
        chk("span_mem31", mem[31], 32'h4321_1111);
        chk("span_mem0",  mem[0], 32'h2222_8765);
`else
        chk("span_k",     r_k, 32'd1);
        chk("span_err",   {31'd0, r_err}, 32'd1);
        chk("span_nwr",   r_nwr, 32'd0);
        chk("span_mem31", mem[31], 32'h1111_1111);
        chk("span_mem0",  mem[0], 32'h2222_2222);
`endif

        // Reset asserted during WR0 suppresses the write and returns to IDLE
        preload(31, 32'hAAAA_AAAA);
        preload(0, 32'hBBBB_BBBB);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
`ifdef MISALIGNED_SPLIT_EN
        bus.req_size  = 3'b010;
        bus.req_addr  = 32'h0000_007E;
        bus.req_wdata = 32'h1234_5678;
`else
        bus.req_size  = 3'b000;
        bus.req_addr  = 32'h0000_0001;
        bus.req_wdata = 32'h0000_005A;
`endif
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int k = 1; k < RST_K; k++) @(negedge clk);
        chk("wr0_strobe", {31'd0, bus.mem_write_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_wr_gate", {31'd0, bus.mem_write_en}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("midrst_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("midrst_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("midrst_state", {29'd0, dbg_state}, 32'd0);
        chk("midrst_mem31", mem[31], 32'hAAAA_AAAA);
        chk("midrst_mem0",  mem[0], 32'hBBBB_BBBB);
        rst_n = 1'b1;

        run_req(1'b0, 3'b010, 32'd0, 32'd0);
        chk("post_lw_data", r_rdata, 32'hBBBB_BBBB);
        chk("post_lw_k",    r_k, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequencer between the CPU load/store port and the word-organised DataMemory, which has 32-bit rows, ignores address bits [1:0] and ignores mem_data_size. The block turns byte, halfword and word loads/stores at any byte address into whole-word memory cycles. Sub-word stores become read-modify-write sequences; accesses that cross a word boundary are split into two word accesses.

## Interface
Parameters:
- ADDR_BITS, default 7: number of byte-address bits decoded. The memory holds 2^(ADDR_BITS-2) words, and word indices wrap modulo that count.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- req_valid  in  1  CPU access request.
- req_ready  out  1  high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  3  RV funct3: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu; any other code is treated as 010.
- req_addr  in  32  byte address; bits at ADDR_BITS and above are ignored.
- req_wdata  in  32  store data, LSB-justified.
- resp_valid  out  1  one-cycle completion pulse; there is no backpressure.
- resp_rdata  out  32  load result, extended per req_size; 0 for stores.
- resp_err  out  1  misaligned access rejected (only when MISALIGNED_SPLIT_EN is undefined).
- mem_access_addr  out  32  {zeros, word_index, 2'b00}.
- mem_in  out  32  merged write word.
- mem_write_en  out  1  memory write strobe.
- mem_read_en  out  1  memory read strobe.
- mem_data_size  out  3  constant 3'b010.
- mem_out  in  32  combinational memory read data, valid in the same cycle as the address.

## Operation
- On req_valid && req_ready, latch the request.
  - off = addr[1:0]; n = 1, 2 or 4 bytes; w0 = addr[ADDR_BITS-1:2]; w1 = w0+1 (wraps).
  - span = (off+n > 4).
- States: IDLE, RD0, RD1, WR0, WR1, RESP.
- Transitions from IDLE on accept:
  - Load: RD0.
  - Store with off=0 and n=4: WR0 (no read).
  - Other stores: RD0.
- RD0 → RD1 if span; else → RESP for loads, WR0 for stores.
- RD1 → RESP for loads, WR0 for stores.
- WR0 → WR1 if span, else RESP.
- WR1 → RESP.
- RESP → IDLE.
- RDx: mem_read_en=1, address = wx, mem_out captured into buf0/buf1.
- Byte order is little-endian. A spanning access uses word0 bytes off..3, then word1 bytes 0..(off+n-5).
- Load result: selected bytes; sign-extended for 000/001, zero-extended for 100/101, unmodified for 010.
- WRx: mem_write_en=1, address = wx. mem_in = bufx with the target bytes replaced by the corresponding req_wdata bytes; an aligned full-word store writes req_wdata directly.
- In IDLE and RESP: mem_read_en, mem_write_en, mem_access_addr and mem_in are all 0.
- mem_write_en is gated by rst_n combinationally, so no write occurs in a reset cycle.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, and all memory outputs 0 except mem_data_size.
- Reset mid-operation abandons the sequence. A split store interrupted between WR0 and WR1 leaves word0 updated and word1 unchanged; this is accepted behaviour.

## Timing
- Cycle k is the k-th cycle after the accept edge. resp_valid is high in:
  - aligned sw: k=2.
  - non-spanning load: k=2.
  - non-spanning sub-word store: k=3.
  - spanning load: k=3.
  - spanning store: k=5.
  - rejected access: k=1.
- resp_valid, resp_rdata and resp_err are registered and hold their values only during the RESP cycle; they are 0 otherwise.
- Earliest next accept is the cycle after RESP, so back-to-back requests are spaced at latency+1 cycles.
- Requests presented while req_ready=0 are ignored and are not queued.

## Configuration
- MISALIGNED_SPLIT_EN defined: spanning accesses are split as described above.
- MISALIGNED_SPLIT_EN undefined:
  - A spanning access goes IDLE → RESP with resp_err=1 and resp_rdata=0.
  - No memory strobe is asserted.
  - Non-spanning misaligned accesses (for example lb at off 3, or lh at off 2) still complete normally.

## Test plan
- word0=0x11228344, lb addr 1 → resp_rdata=0xFFFFFF83 at k=2. Repeat with lbu → 0x00000083.
- word0=0x11223344, sh 0xBEEF at addr 2 → RD0 then WR0 with mem_in=0xBEEF3344; resp_valid at k=3; mem_read_en asserted exactly once.
- sw 0xCAFEF00D at addr 4 → mem_read_en never asserted; WR0 with address 4 and mem_in=0xCAFEF00D; resp_valid at k=2.
- word1=0xDDCCBBAA, word2=0x44332211, lw addr 6:
  - with macro → 0x2211DDCC at k=3.
  - without macro → resp_err=1 and resp_rdata=0 at k=1, with no strobes.
- ADDR_BITS=7, sw 0x87654321 at addr 0x17E (aliases to 0x7E):
  - word31 bytes 2,3 become 0x21 and 0x43.
  - word0 bytes 0,1 become 0x65 and 0x87.
  - resp_valid at k=5.
- Spanning store with rst_n low during WR0 → no write that cycle, state IDLE next cycle, resp_valid stays 0, req_ready=1.
